// File: rtl/ifft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ifft_pkg                                                   |
// | Description : Shared constants, state encoding and index helper for the  |
// |               sequential 8-point inverse FFT (ifft8_seq).                |
// |               Contents: DATA_W_DFLT, N, LOG2N, C_Q15, state_e, bitrev3.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ifft_pkg;

    localparam int DATA_W_DFLT = 16;
    localparam int N           = 8;
    localparam int LOG2N       = 3;

    // cos(pi/4) in Q1.15
    localparam int C_Q15       = 23170;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // Reverse the three index bits so the DIT network sees its input permuted.
    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] v);
        return {v[0], v[1], v[2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifft_butterfly.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ifft_butterfly                                             |
// | Description : Combinational radix-2 IFFT butterfly. Computes t = b*W^k   |
// |               with W = e^{+j2pi/8} and returns (a+t, a-t).               |
// |               Optional macro IFFT_SCALE_EN: halve each output with       |
// |               round-half-up, (v+1)>>>1.                                  |
// | Ports       : a_*_i, b_*_i  operand samples (DATA_W signed)              |
// |               k_i           twiddle exponent 0..3                        |
// |               p_*_o, q_*_o  a+t and a-t                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ifft_butterfly
    import ifft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic signed [DATA_W-1:0] a_re_i,
    input  logic signed [DATA_W-1:0] a_im_i,
    input  logic signed [DATA_W-1:0] b_re_i,
    input  logic signed [DATA_W-1:0] b_im_i,
    input  logic        [1:0]        k_i,
    output logic signed [DATA_W-1:0] p_re_o,
    output logic signed [DATA_W-1:0] p_im_o,
    output logic signed [DATA_W-1:0] q_re_o,
    output logic signed [DATA_W-1:0] q_im_o
);
    // One guard bit so sum/difference of two products never overflows.
    localparam int PW = 2 * DATA_W + 1;
    localparam logic signed [PW-1:0] RND = PW'(1 <<< 14);

    logic signed [PW-1:0]     br_x, bi_x, c_x;
    logic signed [PW-1:0]     m_r, m_i;
    logic signed [PW-1:0]     sum_re, sum_im;
    logic signed [DATA_W-1:0] t_re, t_im;

    assign br_x = PW'(b_re_i);
    assign bi_x = PW'(b_im_i);
    assign c_x  = PW'(C_Q15);
    assign m_r  = br_x * c_x;
    assign m_i  = bi_x * c_x;

    always_comb begin
        sum_re = '0;
        sum_im = '0;
        t_re   = b_re_i;
        t_im   = b_im_i;
        case (k_i)
            2'd1: begin            // W = (C, C)
                sum_re = m_r - m_i;
                sum_im = m_r + m_i;
                t_re   = DATA_W'((sum_re + RND) >>> 15);
                t_im   = DATA_W'((sum_im + RND) >>> 15);
            end
            2'd2: begin            // W = j: rotate by +90 degrees
                t_re = -b_im_i;
                t_im = b_re_i;
            end
            2'd3: begin            // W = (-C, C)
                sum_re = -m_r - m_i;
                sum_im = m_r - m_i;
                t_re   = DATA_W'((sum_re + RND) >>> 15);
                t_im   = DATA_W'((sum_im + RND) >>> 15);
            end
            default: begin         // W = 1: bypass
                t_re = b_re_i;
                t_im = b_im_i;
            end
        endcase
    end

`ifdef IFFT_SCALE_EN
    // Widen before add/sub so the halving sees the unwrapped value.
    logic signed [DATA_W:0] sp_re, sp_im, sq_re, sq_im;
    localparam logic signed [DATA_W:0] ONE = (DATA_W+1)'(1);

    assign sp_re  = (DATA_W+1)'(a_re_i) + (DATA_W+1)'(t_re);
    assign sp_im  = (DATA_W+1)'(a_im_i) + (DATA_W+1)'(t_im);
    assign sq_re  = (DATA_W+1)'(a_re_i) - (DATA_W+1)'(t_re);
    assign sq_im  = (DATA_W+1)'(a_im_i) - (DATA_W+1)'(t_im);
    assign p_re_o = DATA_W'((sp_re + ONE) >>> 1);
    assign p_im_o = DATA_W'((sp_im + ONE) >>> 1);
    assign q_re_o = DATA_W'((sq_re + ONE) >>> 1);
    assign q_im_o = DATA_W'((sq_im + ONE) >>> 1);
`else
    assign p_re_o = a_re_i + t_re;
    assign p_im_o = a_im_i + t_im;
    assign q_re_o = a_re_i - t_re;
    assign q_im_o = a_im_i - t_im;
`endif

endmodule
`default_nettype wire

// File: rtl/ifft8_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ifft8_seq                                                  |
// | Description : Sequential 8-point radix-2 DIT inverse FFT. Loads X[0..7]  |
// |               into a register buffer in bit-reversed order, runs 12      |
// |               in-place butterflies on one shared butterfly, then streams |
// |               x[0..7] out in natural order with backpressure.            |
// |               Optional macro IFFT_SCALE_EN: 1/8 overall scaling.         |
// | Ports       : clk, rst (async, active high)                              |
// |               in_valid/in_ready/in_real/in_imag    sample input          |
// |               out_valid/out_ready/out_real/out_imag/out_last  output     |
// |               busy  high while computing or draining                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ifft8_seq
    import ifft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic              out_last,
    output logic              busy
);
    state_e                   state_q;
    logic [LOG2N-1:0]         cnt_q;     // load count in LOAD, output index in DRAIN
    logic [1:0]               stage_q;
    logic [1:0]               bfly_q;
    logic signed [DATA_W-1:0] buf_re_q [N];
    logic signed [DATA_W-1:0] buf_im_q [N];

    logic [LOG2N-1:0]         p_idx, q_idx;
    logic [1:0]               tw_k;
    logic signed [DATA_W-1:0] bf_p_re, bf_p_im, bf_q_re, bf_q_im;

    // Butterfly addressing per stage, written out per stage instead of the
    // generic shift/mask expression.
    always_comb begin
        p_idx = '0;
        q_idx = '0;
        tw_k  = '0;
        case (stage_q)
            2'd0: begin
                p_idx = {bfly_q, 1'b0};
                q_idx = {bfly_q, 1'b1};
                tw_k  = 2'd0;
            end
            2'd1: begin
                p_idx = {bfly_q[1], 1'b0, bfly_q[0]};
                q_idx = {bfly_q[1], 1'b1, bfly_q[0]};
                tw_k  = {bfly_q[0], 1'b0};
            end
            default: begin
                p_idx = {1'b0, bfly_q};
                q_idx = {1'b1, bfly_q};
                tw_k  = bfly_q;
            end
        endcase
    end

    ifft_butterfly #(
        .DATA_W (DATA_W)
    ) u_bfly (
        .a_re_i (buf_re_q[p_idx]),
        .a_im_i (buf_im_q[p_idx]),
        .b_re_i (buf_re_q[q_idx]),
        .b_im_i (buf_im_q[q_idx]),
        .k_i    (tw_k),
        .p_re_o (bf_p_re),
        .p_im_o (bf_p_im),
        .q_re_o (bf_q_re),
        .q_im_o (bf_q_im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
            for (int i = 0; i < N; i++) begin
                buf_re_q[i] <= '0;
                buf_im_q[i] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    // in_ready is high throughout LOAD, so in_valid alone is a transfer.
                    if (in_valid) begin
                        buf_re_q[bitrev3(cnt_q)] <= in_real;
                        buf_im_q[bitrev3(cnt_q)] <= in_imag;
                        cnt_q <= cnt_q + 3'd1;   // wraps to 0 after the 8th sample
                        if (cnt_q == 3'd7) begin
                            state_q <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    buf_re_q[p_idx] <= bf_p_re;
                    buf_im_q[p_idx] <= bf_p_im;
                    buf_re_q[q_idx] <= bf_q_re;
                    buf_im_q[q_idx] <= bf_q_im;
                    bfly_q <= bfly_q + 2'd1;
                    if (bfly_q == 2'd3) begin
                        if (stage_q == 2'd2) begin
                            stage_q <= '0;
                            state_q <= DRAIN;
                        end else begin
                            stage_q <= stage_q + 2'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != LOAD);
    assign out_last  = out_valid && (cnt_q == 3'd7);
    assign out_real  = out_valid ? buf_re_q[cnt_q] : '0;
    assign out_imag  = out_valid ? buf_im_q[cnt_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ifft8_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ifft8_seq                                               |
// | Description : Self-checking bench for ifft8_seq. Expected outputs come   |
// |               from hand-derived inverse DFT tables (with IFFT_SCALE_EN   |
// |               variants) pushed to a scoreboard queue per frame.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ifft8_seq;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_real = '0;
    logic [DATA_W-1:0] in_imag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_imag;
    logic              out_last;
    logic              busy;

    ifft8_seq #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
        int last;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   fr_re [8];
    int   fr_im [8];
    int   ex_re [8];
    int   ex_im [8];

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sre(input logic [DATA_W-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic push_expected();
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.re = ex_re[i];
            e.im = ex_im[i];
            e.last = (i == 7) ? 1 : 0;
            sb.push_back(e);
        end
    endtask

    // Stream fr_re/fr_im in, one sample per cycle.
    task automatic send_frame();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_real  = DATA_W'(fr_re[i]);
            in_imag  = DATA_W'(fr_im[i]);
            check("in_ready_load", int'(in_ready), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_real  = '0;
        in_imag  = '0;
    endtask

    // Count edges from last input accept until out_valid; optionally drive
    // junk inputs meanwhile, which must be ignored.
    task automatic wait_compute(input bit junk);
        int n = 0;
        if (junk) begin
            in_valid = 1'b1;
            in_real  = 16'h7fff;
            in_imag  = 16'h8001;
        end
        while (!out_valid && n < 40) begin
            check("busy_compute", int'(busy), 1);
            @(posedge clk); #1;
            n++;
        end
        check("compute_latency", n, 12);
        check("in_ready_compute", int'(in_ready), 0);
    endtask

    // Drain 8 outputs; bp selects the 1,0,0,1 out_ready pattern.
    task automatic drain(input bit bp);
        int   cyc = 0;
        int   got = 0;
        bit   stalled;
        int   h_re, h_im, h_last;
        exp_t e;
        while (got < 8 && cyc < 200) begin
            out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            stalled = 1'b0;
            if (out_valid) begin
                check("in_ready_drain", int'(in_ready), 0);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("scoreboard_empty", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_real", sre(out_real), e.re);
                        check("out_imag", sre(out_imag), e.im);
                        check("out_last", int'(out_last), e.last);
                    end
                    got++;
                end else begin
                    stalled = 1'b1;
                    h_re    = sre(out_real);
                    h_im    = sre(out_imag);
                    h_last  = int'(out_last);
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (stalled) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_real", sre(out_real), h_re);
                check("hold_imag", sre(out_imag), h_im);
                check("hold_last", int'(out_last), h_last);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drain_count", got, 8);
        check("in_ready_after_last", int'(in_ready), 1);
        check("out_valid_after_last", int'(out_valid), 0);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = 0; fr_im[i] = 0; ex_re[i] = 0; ex_im[i] = 0;
        end
    endtask

    task automatic impulse_tables();
        clear_frame();
        fr_re[0] = 8;
        for (int i = 0; i < 8; i++) begin
`ifdef IFFT_SCALE_EN
            ex_re[i] = 1;
`else
            ex_re[i] = 8;
`endif
        end
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_real", sre(out_real), 0);
        check("rst_out_imag", sre(out_imag), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Impulse
        impulse_tables();
        push_expected();
        send_frame();
        wait_compute(1'b0);
        drain(1'b0);

        // Constant
        clear_frame();
        for (int i = 0; i < 8; i++) fr_re[i] = 8;
`ifdef IFFT_SCALE_EN
        ex_re[0] = 8;
`else
        ex_re[0] = 64;
`endif
        push_expected();
        send_frame();
        wait_compute(1'b0);
        drain(1'b0);

        // Single tone at bin 1
        clear_frame();
        fr_re[1] = 1024;
`ifdef IFFT_SCALE_EN
        ex_re = '{128, 91, 0, -90, -128, -90, 0, 91};
        ex_im = '{0, 91, 128, 91, 0, -90, -128, -90};
`else
        ex_re = '{1024, 724, 0, -724, -1024, -724, 0, 724};
        ex_im = '{0, 724, 1024, 724, 0, -724, -1024, -724};
`endif
        push_expected();
        send_frame();
        wait_compute(1'b0);
        drain(1'b0);

        // Same tone with backpressure
        push_expected();
        send_frame();
        wait_compute(1'b0);
        drain(1'b1);

        // Overflow wrap, with junk offered on the input during compute
        clear_frame();
        for (int i = 0; i < 8; i++) fr_re[i] = 16384;
`ifdef IFFT_SCALE_EN
        ex_re[0] = 16384;
`endif
        push_expected();
        send_frame();
        wait_compute(1'b1);
        drain(1'b0);

        // Reset five cycles into COMPUTE
        impulse_tables();
        send_frame();
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_in_ready_async", int'(in_ready), 1);
        @(posedge clk); #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fresh impulse frame after reset
        impulse_tables();
        push_expected();
        send_frame();
        wait_compute(1'b0);
        drain(1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute guard against a hang.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/ifft8_seq.md
# ifft8_seq

Sequential 8-point radix-2 decimation-in-time inverse FFT. It is the receive-side counterpart of the combinational forward FFT datapath. Complex frequency-domain samples are streamed in over a valid/ready interface and stored in an internal register buffer. A single time-shared butterfly computes the 12 butterflies in place, and the eight time-domain samples are streamed out in natural order with backpressure.

## Interface
Parameters:
- DATA_W, 16: width of each real/imag component, two's complement.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample; high only in LOAD.
- in_real  in  DATA_W  real part of X[k], k in natural order 0..7.
- in_imag  in  DATA_W  imag part of X[k].
- out_valid  out  1  output sample valid; high only in DRAIN.
- out_ready  in  1  downstream accepts the output sample.
- out_real  out  DATA_W  real part of x[n], n in natural order 0..7.
- out_imag  out  DATA_W  imag part of x[n].
- out_last  out  1  high with x[7].
- busy  out  1  high in COMPUTE and DRAIN.

## Operation
- States are LOAD, COMPUTE and DRAIN. Reset enters LOAD.
- LOAD:
  - A transfer occurs when in_valid and in_ready are both high.
  - Sample number cnt (0..7) is written to buf[bitrev3(cnt)].
  - After the 8th transfer the state goes to COMPUTE and cnt clears.
- COMPUTE runs one butterfly per cycle, 12 cycles in total.
  - Stage s = 0..2 and butterfly b = 0..3, b incrementing fastest.
  - span = 1<<s.
  - p = ((b>>s)<<(s+1)) | (b & (span-1)), and q = p+span.
  - Twiddle exponent k = (b & (span-1)) << (2-s).
  - Twiddle is W = e^{+j2πk/8}, in Q1.15 with C = 23170:
    - k=0: (1,0) — bypass, no multiply.
    - k=1: (C,C).
    - k=2: (0,1) — t = (−b_im, b_re), no multiply.
    - k=3: (−C,C).
  - For k=1 and k=3: 32-bit product, then t = (sum + 2^14) >>> 15, truncated to DATA_W.
  - Results are written back as buf[p] = a+t and buf[q] = a−t.
  - After s=2, b=3 the state goes to DRAIN.
- Arithmetic is DATA_W two's complement, wrapping on overflow, with no saturation.
- DRAIN:
  - out_real and out_imag present buf[idx].
  - idx advances when out_valid and out_ready are both high.
  - out_last = (idx==7).
  - A transfer at idx 7 returns the state to LOAD.
- No input is accepted outside LOAD. in_valid in COMPUTE or DRAIN is ignored and no data is lost.
- Reset at any point, including mid-COMPUTE or mid-DRAIN:
  - buffer and counters clear.
  - state returns to LOAD.
  - the partial frame is discarded.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0, out_last=0
  - out_real=0, out_imag=0
  - busy=0
- in_ready and out_valid are decoded from registered state only. There is no combinational path from input to output.
- If the last input is accepted at edge T:
  - COMPUTE occupies cycles T+1..T+12.
  - out_valid rises after edge T+12, so the first output is presented in cycle T+13.
- With out_ready held high, the eight outputs take 8 consecutive cycles and in_ready rises the cycle after x[7] transfers.
- Minimum frame period is 28 cycles (8 load, 12 compute, 8 drain).
- When out_ready is low, out_real, out_imag and out_last hold stable.

## Configuration
- IFFT_SCALE_EN defined:
  - each butterfly output (a±t) is arithmetic-shifted right by 1 with round-half-up, i.e. (v+1)>>>1.
  - the total scaling is 1/8, giving the true inverse DFT.
- Undefined: no scaling. The output is the unnormalised inverse DFT, sum of X[k]·e^{+j2πkn/8}, wrapping at DATA_W.

## Structure
- Package ifft_pkg holds:
  - DATA_W default, N=8, LOG2N=3.
  - Q15 constant C_Q15 = 23170.
  - the state enum {LOAD, COMPUTE, DRAIN}.
  - the bitrev3 function.
- One sub-module, ifft_butterfly: combinational. It takes a, b and k and produces a+t and a−t, and contains the twiddle select, the multiplier and the IFFT_SCALE_EN scaling.

## Test plan
All scenarios are unscaled unless noted.
- Impulse: X[0]=(8,0), others 0 → all x[n]=(8,0). With IFFT_SCALE_EN → all x[n]=(1,0).
- Constant: all X[k]=(8,0) → x[0]=(64,0), others (0,0). Scaled → x[0]=(8,0), others 0.
- Single tone: X[1]=(1024,0), others 0 → x[0..7]:
  - (1024,0), (724,724), (0,1024), (−724,724)
  - (−1024,0), (−724,−724), (0,−1024), (724,−724)
  - out_last is high on x[7] only.
- Backpressure: same tone, out_ready toggled 1,0,0,1,… → outputs unchanged while stalled. in_ready stays 0 until x[7] transfers.
- Overflow wrap: all X[k]=(16384,0) → x[0]=(0,0) (131072 mod 2^16), others 0.
- Reset mid-COMPUTE: assert rst 5 cycles into COMPUTE → next cycle:
  - out_valid=0 and in_ready=1.
  - a fresh impulse frame then produces correct results.
